// File: rtl/pro_ele_pkg.sv
// Shared types and constants for the single-neuron processing element.
// FP32 field widths, well-known encodings and the controller state encoding.
package pro_ele_pkg;

  localparam int COUNT_W = 10;

  localparam int FP_SIGN_W = 1;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MAN_W  = 23;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_INF  = 32'h7F80_0000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_BIAS = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ACC  = ST_ACC,
    BIAS = ST_BIAS,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/pro_ele_fp32_mac.sv
// Combinational fused FP32 y = a*m + c: single truncation at the end, denormals flush to +0,
// overflow saturates to signed Inf. The full 48-bit product is kept so only the sum is rounded.
module fp32_mac
  import pro_ele_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] m,
  input  logic [31:0] c,
  output logic [31:0] y
);

  logic                p_sign, c_sign, res_sign, sub, swap, sticky;
  logic                p_zero, c_zero, p_inf, c_inf;
  logic [47:0]         prod, p_man, c_man;
  logic [FP_EXP_W-1:0] p_exp, c_exp, big_exp, exp_diff;
  logic [55:0]         p_key, c_key;
  logic [74:0]         big_ext, small_ext, small_al, sum;
  logic [149:0]        shifted;
  logic [6:0]          lead;
  int                  p_exp_raw, e_res;

  assign prod = 48'({1'b1, a[FP_MAN_W-1:0]}) * 48'({1'b1, m[FP_MAN_W-1:0]});

  always_comb begin
    p_sign    = a[31] ^ m[31];
    c_sign    = c[31];
    c_exp     = c[30:23];
    p_exp_raw = int'(a[30:23]) + int'(m[30:23]) - 127 + (prod[47] ? 1 : 0);
    // Both operands are normalised with the hidden one at bit 47.
    p_man     = prod[47] ? prod : {prod[46:0], 1'b0};
    c_man     = {1'b1, c[FP_MAN_W-1:0], 24'd0};
    p_inf     = (a[30:23] == 8'hFF) || (m[30:23] == 8'hFF) || (p_exp_raw >= 255);
    p_zero    = (a[30:23] == 8'h00) || (m[30:23] == 8'h00) || (p_exp_raw <= 0);
    c_inf     = (c_exp == 8'hFF);
    c_zero    = (c_exp == 8'h00);
    p_exp     = 8'(p_exp_raw);

    p_key     = p_zero ? 56'd0 : {p_exp, p_man};
    c_key     = c_zero ? 56'd0 : {c_exp, c_man};
    swap      = c_key > p_key;
    big_exp   = swap ? c_exp : p_exp;
    exp_diff  = swap ? (c_exp - p_exp) : (p_exp - c_exp);
    big_ext   = swap ? (c_zero ? 75'd0 : {1'b0, c_man, 26'd0})
                     : (p_zero ? 75'd0 : {1'b0, p_man, 26'd0});
    small_ext = swap ? (p_zero ? 75'd0 : {1'b0, p_man, 26'd0})
                     : (c_zero ? 75'd0 : {1'b0, c_man, 26'd0});

    shifted   = {small_ext, 75'd0} >> ((exp_diff > 8'd63) ? 8'd63 : exp_diff);
    small_al  = shifted[149:75];
    sticky    = |shifted[74:0];
    sub       = p_sign ^ c_sign;
    // Lost bits borrow one LSB so the truncated difference rounds toward zero.
    sum       = sub ? (big_ext - small_al - 75'(sticky)) : (big_ext + small_al);
    res_sign  = swap ? c_sign : p_sign;

    lead = 7'd0;
    for (int i = 0; i < 75; i++) begin
      if (sum[i]) lead = 7'(i);
    end
    e_res = int'(big_exp) + int'(lead) - 73;

    y = FP_ZERO;
    if (p_inf)               y = {p_sign, FP_INF[30:0]};
    else if (c_inf)          y = {c_sign, FP_INF[30:0]};
    else if (sum == 75'd0)   y = FP_ZERO;
    else if (e_res >= 255)   y = {res_sign, FP_INF[30:0]};
    else if (e_res <= 0)     y = FP_ZERO;
    else                     y = {res_sign, 8'(e_res), 23'((sum << (7'd74 - lead)) >> 51)};
  end

endmodule

// File: rtl/pro_ele.sv
// Single-neuron PE: head loads a count, N MAC cycles, one bias cycle; result at H+N+1, held until head/reset.
// Optional ReLU on the registered result is enabled by defining PE_RELU_EN.
module pro_ele
  import pro_ele_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] w,
  input  logic [31:0] x_in,
  input  logic [31:0] b,
  input  logic        head,
  output logic [31:0] pe_out,
  output logic        done_flag
);

  state_e             state_q, state_d;
  logic [31:0]        acc_q, acc_d, pe_out_q, pe_out_d;
  logic [31:0]        mac_a, mac_m, mac_y;
  logic [COUNT_W-1:0] cnt_q, cnt_d, final_count_q, final_count_d, cnt_inc;
  logic               done_q, done_d;

  // The bias step reuses the MAC as 1.0*b + acc.
  assign mac_a = (state_q == BIAS) ? FP_ONE : w;
  assign mac_m = (state_q == BIAS) ? b : x_in;

  fp32_mac u_mac (
    .a (mac_a),
    .m (mac_m),
    .c (acc_q),
    .y (mac_y)
  );

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    final_count_d = final_count_q;
    pe_out_d      = pe_out_q;
    done_d        = done_q;
    if (head) begin
      final_count_d = x_in[COUNT_W-1:0];
      acc_d         = FP_ZERO;
      cnt_d         = '0;
      done_d        = 1'b0;
      state_d       = (x_in[COUNT_W-1:0] == '0) ? BIAS : ACC;
    end else begin
      case (state_q)
        ACC: begin
          acc_d = mac_y;
          cnt_d = cnt_inc;
          if (cnt_inc == final_count_q) state_d = BIAS;
        end
        BIAS: begin
`ifdef PE_RELU_EN
          pe_out_d = mac_y[31] ? FP_ZERO : mac_y;
`else
          pe_out_d = mac_y;
`endif
          done_d  = 1'b1;
          state_d = DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      acc_q         <= FP_ZERO;
      cnt_q         <= '0;
      final_count_q <= '0;
      pe_out_q      <= FP_ZERO;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      final_count_q <= final_count_d;
      pe_out_q      <= pe_out_d;
      done_q        <= done_d;
    end
  end

  assign pe_out    = pe_out_q;
  assign done_flag = done_q;

endmodule

// File: tb/tb_pro_ele.sv
// Directed bench for pro_ele: expected results are queued at head time and popped when done_flag rises.
module tb_pro_ele;

  logic        clock = 1'b0;
  logic        reset, head;
  logic [31:0] w, x_in, b;
  logic [31:0] pe_out;
  logic        done_flag;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_out;

  pro_ele dut (
    .clock     (clock),
    .reset     (reset),
    .w         (w),
    .x_in      (x_in),
    .b         (b),
    .head      (head),
    .pe_out    (pe_out),
    .done_flag (done_flag)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Called at a falling edge; drives head, then holds w/x_in/b until done_flag or budget.
  task automatic run_neuron(input string tag, input logic [9:0] n, input logic [31:0] wv,
                            input logic [31:0] xv, input logic [31:0] bv, input logic [31:0] expv);
    int cyc;
    head = 1'b1;
    x_in = {22'd0, n};
    w    = 32'h0;
    b    = bv;
    exp_q.push_back(expv);
    @(negedge clock);
    check({tag, "_done_clr"}, {31'd0, done_flag}, 32'd0);
    check({tag, "_hold"}, pe_out, last_out);
    head = 1'b0;
    x_in = xv;
    w    = wv;
    cyc  = 0;
    while (done_flag !== 1'b1 && cyc < int'(n) + 8) begin
      @(negedge clock);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(int'(n) + 1));
    check({tag, "_out"}, pe_out, exp_q.pop_front());
    last_out = expv;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    head  = 1'b0;
    w     = 32'h0;
    x_in  = 32'h0;
    b     = 32'h0;
    last_out = 32'h0;
    repeat (2) @(negedge clock);
    check("reset_pe_out", pe_out, 32'h0);
    check("reset_done", {31'd0, done_flag}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // 9 * (0.5 * 0.25) + 1.0 = 2.125
    run_neuron("basic", 10'd9, 32'h3F00_0000, 32'h3E80_0000, 32'h3F80_0000, 32'h4008_0000);
    repeat (3) @(negedge clock);
    check("done_level", {31'd0, done_flag}, 32'd1);
    check("done_hold_out", pe_out, 32'h4008_0000);

    run_neuron("restart", 10'd1, 32'h4000_0000, 32'h4000_0000, 32'h0, 32'h4080_0000);
    run_neuron("zero_cnt", 10'd0, 32'h1234_5678, 32'h3F80_0000, 32'h4040_0000, 32'h4040_0000);
`ifdef PE_RELU_EN
    run_neuron("negative", 10'd2, 32'hC000_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000);
`else
    run_neuron("negative", 10'd2, 32'hC000_0000, 32'h3F80_0000, 32'h3F80_0000, 32'hC040_0000);
`endif
    // 1.0 + 2^-24 truncates to 1.0; 1.0 - 2^-25 truncates to the float just below 1.0
    run_neuron("rtz_add", 10'd1, 32'h3380_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
    run_neuron("rtz_sub", 10'd1, 32'hB300_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F7F_FFFF);
    run_neuron("overflow", 10'd1, 32'h7F00_0000, 32'h4000_0000, 32'h0, 32'h7F80_0000);
    run_neuron("denorm", 10'd1, 32'h0040_0000, 32'h3F80_0000, 32'h0, 32'h0000_0000);
    run_neuron("fresh", 10'd1, 32'h3F80_0000, 32'h4000_0000, 32'h0, 32'h4000_0000);

    // Abort mid-accumulation: the partial sum must be discarded.
    head = 1'b1;
    x_in = 32'd3;
    b    = 32'h0;
    @(negedge clock);
    head = 1'b0;
    x_in = 32'h3F80_0000;
    w    = 32'h3F80_0000;
    @(negedge clock);
    check("abort_done", {31'd0, done_flag}, 32'd0);
    check("abort_hold", pe_out, last_out);
    run_neuron("abort", 10'd2, 32'h3F80_0000, 32'h4000_0000, 32'h0, 32'h4080_0000);

    // Reset after two MACs of a 5-count neuron.
    head = 1'b1;
    x_in = 32'd5;
    b    = 32'h3F80_0000;
    @(negedge clock);
    head = 1'b0;
    x_in = 32'h3F80_0000;
    w    = 32'h3F80_0000;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_out", pe_out, 32'h0);
    check("rst_mid_done", {31'd0, done_flag}, 32'd0);
    reset = 1'b0;
    last_out = 32'h0;
    for (int i = 0; i < 4; i++) begin
      w    = $urandom;
      x_in = $urandom;
      b    = $urandom;
      @(negedge clock);
      check("idle_out", pe_out, 32'h0);
      check("idle_done", {31'd0, done_flag}, 32'd0);
    end

    run_neuron("zero_w", 10'd4, 32'h0000_0000, 32'h3F80_0000, 32'h3E80_0000, 32'h3E80_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
